// File: rtl/ldpc_enc_framer_pkg.sv
// Shared types and constants for the LDPC encoder framer: FSM state encoding,
// clogb2 and the default frame geometry derived from the codebase code length.
package ldpc_enc_framer_pkg;

  typedef enum logic [1:0] {cIDLE, cPAYLOAD, cFILL} state_t;

  localparam int unsigned cLDPC_NUM  = 576;
  localparam int unsigned cLDPC_DNUM = 288;
  localparam int unsigned cDAT_W     = 8;

  // Bits needed to hold 0..value-1; never less than one.
  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned w;
    w = 0;
    for (int i = 0; i < 32; i++) begin
      if ((32'd1 << i) < value) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

  localparam int unsigned cCNT_W = clogb2(cLDPC_NUM / cDAT_W);

endpackage

// File: rtl/ldpc_enc_framer_if.sv
// Source-side and encoder-side handshake bundle of the LDPC encoder framer.
// master: the framer itself; slave: the source/encoder environment around it.
interface ldpc_enc_framer_if #(
  parameter int unsigned pDAT_W = 8,
  parameter int unsigned pTAG_W = 4
);

  logic              ival;
  logic [pTAG_W-1:0] itag;
  logic [pDAT_W-1:0] idat;
  logic              ordy;
  logic              ienc_rdy;
  logic              osop;
  logic              oeop;
  logic              oeof;
  logic              oval;
  logic [pTAG_W-1:0] otag;
  logic [pDAT_W-1:0] odat;

  modport master (
    input  ival, itag, idat, ienc_rdy,
    output ordy, osop, oeop, oeof, oval, otag, odat
  );

  modport slave (
    output ival, itag, idat, ienc_rdy,
    input  ordy, osop, oeop, oeof, oval, otag, odat
  );

endinterface

// File: rtl/ldpc_enc_framer.sv
// Builds encoder frames: pDNUM payload words from the source, then zero filler up to pNUM.
// Optional LDPC_ENC_FRAMER_CNT_EN adds ofrm_cnt, a count of completed frames.
module ldpc_enc_framer
  import ldpc_enc_framer_pkg::*;
#(
  parameter int unsigned pDAT_W = cDAT_W,
  parameter int unsigned pTAG_W = 4,
  parameter int unsigned pDNUM  = cLDPC_DNUM / pDAT_W,
  parameter int unsigned pNUM   = cLDPC_NUM / pDAT_W
) (
  input  logic                iclk,
  input  logic                iresetn,
  input  logic                iclkena,
  input  logic                iclear,
`ifdef LDPC_ENC_FRAMER_CNT_EN
  output logic [15:0]         ofrm_cnt,
`endif
  ldpc_enc_framer_if.master   bus
);

  localparam int unsigned cW = clogb2(pNUM);

  state_t          state;
  logic [cW-1:0]   cnt;

  assign bus.ordy = (state == cIDLE || state == cPAYLOAD) && bus.ienc_rdy && !iclear;

  // Output word only moves when the encoder can take it, so a stalled word is never altered.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      state    <= cIDLE;
      cnt      <= '0;
      bus.oval <= 1'b0;
      bus.osop <= 1'b0;
      bus.oeop <= 1'b0;
      bus.oeof <= 1'b0;
      bus.odat <= '0;
      bus.otag <= '0;
    end else if (iclkena) begin
      if (iclear) begin
        state    <= cIDLE;
        cnt      <= '0;
        bus.oval <= 1'b0;
        bus.osop <= 1'b0;
        bus.oeop <= 1'b0;
        bus.oeof <= 1'b0;
      end else if (bus.ienc_rdy) begin
        bus.oval <= 1'b0;
        bus.osop <= 1'b0;
        bus.oeop <= 1'b0;
        bus.oeof <= 1'b0;
        unique case (state)
          cIDLE: begin
            if (bus.ival) begin
              bus.oval <= 1'b1;
              bus.osop <= 1'b1;
              bus.oeop <= (pDNUM == 1);
              bus.odat <= bus.idat;
              bus.otag <= bus.itag;
              cnt      <= cW'(1);
              state    <= (pDNUM == 1) ? cFILL : cPAYLOAD;
            end
          end
          cPAYLOAD: begin
            // No source word here is a bubble; the frame simply continues later.
            if (bus.ival) begin
              bus.oval <= 1'b1;
              bus.odat <= bus.idat;
              cnt      <= cnt + 1'b1;
              if (cnt == cW'(pDNUM - 1)) begin
                bus.oeop <= 1'b1;
                state    <= cFILL;
              end
            end
          end
          cFILL: begin
            bus.oval <= 1'b1;
            bus.odat <= '0;
            if (cnt == cW'(pNUM - 1)) begin
              bus.oeof <= 1'b1;
              cnt      <= '0;
              state    <= cIDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= cIDLE;
        endcase
      end
    end
  end

`ifdef LDPC_ENC_FRAMER_CNT_EN
  // Frame count survives iclear; only reset clears it.
  always_ff @(posedge iclk or negedge iresetn) begin
    if (!iresetn) begin
      ofrm_cnt <= '0;
    end else if (iclkena && bus.oval && bus.oeof && bus.ienc_rdy) begin
      ofrm_cnt <= ofrm_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/ldpc_enc_framer.md
Name: ldpc_enc_framer

Overview:
- Upstream framing stage for ldpc_enc.
- Accepts a plain payload word stream with a valid/ready handshake and builds the encoder frame. Each frame is pDNUM payload words, then (pNUM-pDNUM) filler words.
- Generates the sop/eop/eof/val/tag strobes the encoder expects and honours the encoder's ready signal.
- Frame geometry is static per instance.

Parameters:
- pDAT_W, 8, encoder word width in bits.
- pTAG_W, 4, frame tag width.
- pDNUM, 36, payload words per frame (576-bit code, rate 1/2, 8-bit words).
- pNUM, 72, total words per frame; must be > pDNUM.

Ports:
- iclk      in   1        clock
- iresetn   in   1        asynchronous active-low reset
- iclkena   in   1        clock enable; all state frozen when low
- iclear    in   1        synchronous abort of the current frame
- ival      in   1        source word valid
- itag      in   pTAG_W   source tag; sampled on the first payload word of a frame
- idat      in   pDAT_W   source payload word
- ordy      out  1        ready to source
- ienc_rdy  in   1        encoder ordy
- osop      out  1        start of frame to encoder
- oeop      out  1        end of payload to encoder
- oeof      out  1        end of frame to encoder
- oval      out  1        word valid to encoder
- otag      out  pTAG_W   tag to encoder
- odat      out  pDAT_W   data to encoder

Behaviour:
- Reset (iresetn low, asynchronous): state=cIDLE, counter=0, oval=0, osop=0, oeop=0, oeof=0, odat=0, otag=0.
- Upstream handshake:
  - Source transfer = ival & ordy & iclkena.
  - ordy = (state==cIDLE | state==cPAYLOAD) & ienc_rdy & ~iclear; ordy is 0 in cFILL.
- Downstream registers:
  - Output registers update only when iclkena & ienc_rdy, and otherwise hold.
  - Encoder transfer = oval & ienc_rdy.
  - A word is never changed while ienc_rdy=0, which covers the encoder's single-cycle GET_P1 stall.
- Word counter: cnt, width clogb2(pNUM); counts words pushed to the output register.
- FSM:
  - cIDLE: on a source transfer, load the output with osop=1, oval=1, odat=idat; latch otag=itag; cnt=1.
    - If pDNUM==1, also assert oeop and go to cFILL; otherwise go to cPAYLOAD.
  - cPAYLOAD: each source transfer gives oval=1, odat=idat, cnt++.
    - When cnt==pDNUM-1, that word carries oeop=1 and the FSM goes to cFILL.
    - With no source transfer (and ienc_rdy=1), oval=0; this is a bubble and the frame continues.
  - cFILL: while ienc_rdy, emit oval=1, odat=0, cnt++.
    - When cnt==pNUM-1, that word carries oeof=1, and the FSM goes to cIDLE with cnt=0.
- osop, oeop and oeof are each asserted for exactly one valid word per frame.
- Back-to-back frames: the first word of the next frame may be accepted in the cycle after the oeof word is registered. There is no mandatory gap.
- Latency: 1 cycle from source transfer to oval (at ienc_rdy=1).
- iclear (when iclkena):
  - Forces cIDLE, cnt=0, oval=0 and all strobes 0 on the next edge, dropping the partial frame.
  - The encoder recovers on the next osop.
  - iclear has priority over a simultaneous source transfer, which is not accepted because ordy=0.
- iclkena low: no transfers occur, and ordy stays combinational per the ordy rule above.

Optional Feature:
- Macro: LDPC_ENC_FRAMER_CNT_EN.
- When defined:
  - Adds output ofrm_cnt [15:0].
  - ofrm_cnt increments (wrapping modulo 2^16) on each encoder transfer that carries oeof=1.
  - It is cleared by reset only; iclear does not clear it.
- When undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package ldpc_enc_framer_pkg holds:
  - the state enum {cIDLE, cPAYLOAD, cFILL};
  - clogb2;
  - the derived counter width constant.
- pDNUM and pNUM are instantiated from the codebase values cLDPC_DNUM/pDAT_W and cLDPC_NUM/pDAT_W.
- No sub-module: single flat module.

Test Plan:
- Single frame, ival=1 and ienc_rdy=1 throughout:
  - 72 oval words;
  - osop on word 0, oeop on word 35, oeof on word 71;
  - words 36..71 have odat=0;
  - ordy=0 for exactly 36 cycles during cFILL.
- Encoder stall: ienc_rdy=0 for 1 cycle right after the oeop word:
  - outputs hold;
  - the filler count stays at 36 words, with no duplicate or lost word.
- Source bubbles: ival toggled 1010… during the payload:
  - odat sequence equals the idat sequence;
  - oeop lands on the 36th payload word.
- Back-to-back frames with itag=3 then itag=9:
  - second osop appears in the cycle after the first oeof;
  - otag=3 for the first frame and 9 for the second.
- iclear at payload word 10: oval drops next cycle; the next frame starts cleanly with osop, and oeop again on its 36th word.
- Reset mid-fill, iresetn low asynchronously: all outputs 0 immediately. With LDPC_ENC_FRAMER_CNT_EN, ofrm_cnt reads 2 after two full frames and 0 after reset.
